// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, bit positions and CTRL layout shared by the UART RX FIFO.
package uart_pkg;
   localparam logic [7:0] UART_RXF_CTRL   = 8'h00;
   localparam logic [7:0] UART_RXF_STATUS = 8'h04;
   localparam logic [7:0] UART_RXF_DATA   = 8'h08;
   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int CTRL_FLUSH_BIT  = 2;
   localparam int CTRL_THR_LSB    = 4;
   localparam int ST_OVF_BIT      = 2;
   typedef struct packed {
      logic [7:0] threshold;
      logic       irq_en;
      logic       enable;
   } ctrl_t;
endpackage

// File: rtl/sync_fifo_ptr.sv
// sync_fifo_ptr: byte circular buffer with push/pop/flush, occupancy and drop-on-full indication.
module sync_fifo_ptr #(
   parameter int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [7:0]       data_i,
   output logic [7:0]       head_o,
   output logic [PTR_W:0]   count_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             drop_o
);
   logic [7:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PTR_W:0] count_q, count_d;
   logic push_ok, pop_ok;
   always_comb begin
      empty_o = count_q == '0;
      full_o  = count_q == (PTR_W+1)'(DEPTH);
      pop_ok  = pop_i && !empty_o && !flush_i;
      // a pop frees the slot, so a push into a full buffer is still accepted
      push_ok = push_i && !flush_i && (!full_o || pop_ok);
      drop_o  = push_i && !flush_i && full_o && !pop_ok;
      wptr_d  = flush_i ? '0 : wptr_q + PTR_W'(push_ok);
      rptr_d  = flush_i ? '0 : rptr_q + PTR_W'(pop_ok);
      count_d = flush_i ? '0 : count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
      head_o  = mem_q[rptr_q];
      count_o = count_q;
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wptr_q] <= data_i;
   end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive FIFO with CTRL/STATUS/DATA register window and threshold/overflow interrupt.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   input  logic        wr_en_i,
   input  logic [31:0] wr_addr_i,
   input  logic [31:0] wr_data_i,
   input  logic        rd_en_i,
   input  logic [31:0] rd_addr_i,
   output logic [31:0] rd_data_o,
   output logic        irq_o
);
   ctrl_t ctrl_q, ctrl_d;
   logic overflow_q, overflow_d, irq_q, irq_d;
   logic [PTR_W:0] count;
   logic [7:0] head, wa, ra;
   logic [8:0] thr_eff;
   logic empty, full, drop, flush_req, ctrl_wr, ovf_clr, pop_req, thresh_hit;
   logic unused_bits;
   assign wa = wr_addr_i[7:0];
   assign ra = rd_addr_i[7:0];
   assign unused_bits = ^{wr_addr_i[31:8], rd_addr_i[31:8], wr_data_i[31:12], wr_data_i[3]};
   sync_fifo_ptr #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (rx_valid_i && ctrl_q.enable),
      .pop_i   (pop_req),
      .flush_i (flush_req),
      .data_i  (rx_data_i),
      .head_o  (head),
      .count_o (count),
      .empty_o (empty),
      .full_o  (full),
      .drop_o  (drop)
   );
   always_comb begin
      ctrl_wr    = wr_en_i && wa == UART_RXF_CTRL;
      flush_req  = ctrl_wr && wr_data_i[CTRL_FLUSH_BIT];
      ovf_clr    = wr_en_i && wa == UART_RXF_STATUS && wr_data_i[ST_OVF_BIT];
      pop_req    = rd_en_i && ra == UART_RXF_DATA;
      ctrl_d     = ctrl_wr ? ctrl_t'{threshold: wr_data_i[CTRL_THR_LSB +: 8],
                                     irq_en: wr_data_i[CTRL_IRQ_EN_BIT],
                                     enable: wr_data_i[CTRL_EN_BIT]} : ctrl_q;
      // threshold 0 behaves as 1 and anything beyond DEPTH as DEPTH
      thr_eff    = ctrl_q.threshold == '0 ? 9'd1 :
                   9'(ctrl_q.threshold) > 9'(DEPTH) ? 9'(DEPTH) : 9'(ctrl_q.threshold);
      thresh_hit = 9'(count) >= thr_eff;
      overflow_d = drop || (overflow_q && !ovf_clr);
      irq_d      = ctrl_q.irq_en && (thresh_hit || overflow_q);
      rd_data_o  = ra == UART_RXF_CTRL   ? {20'b0, ctrl_q.threshold, 2'b0, ctrl_q.irq_en, ctrl_q.enable} :
                   ra == UART_RXF_STATUS ? {7'b0, 9'(count), 12'b0, thresh_hit, overflow_q, full, empty} :
                   ra == UART_RXF_DATA   ? {23'b0, empty, empty ? 8'h00 : head} : 32'b0;
      irq_o      = irq_q;
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ctrl_q     <= '0;
         overflow_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         overflow_q <= overflow_d;
         irq_q      <= irq_d;
      end
   end
endmodule
